hdmi_cfg_sequencer: RTL and testbench

Sequences the HDMI transmitter power-up configuration. It walks the configuration ROM as {device address, register address, data} byte triples and hands each triple to the I2C byte-write master over a req/ack/done handshake. It retries NACKed writes and reports done or error to the top level. It sits between the configuration ROM and the I2C master, on the same reference clock domain.

---
 rtl/hdmi_cfg_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_hdmi_cfg_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_cfg_sequencer.sv
// HDMI transmitter power-up sequencer: walks a ROM of {device, register, data}
// byte triples and issues each as an I2C byte write, retrying NACKed writes.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for start after reset
// FETCH_DEV  | reading device byte of current entry (END_MARKER ends table)
// FETCH_REG  | reading register byte of current entry
// FETCH_DATA | reading data byte of current entry
// ISSUE      | wr_req raised, waiting for the master to accept
// WAIT       | request accepted, waiting for wr_done / wr_nack
// GAP        | idle spacing after every write, then next entry/retry/exit
// DONE       | table completed (sticky until start)
// ERROR      | retries exhausted on entry_idx (sticky until start)
module hdmi_cfg_sequencer #(
    parameter int         NUM_ENTRIES = 25,
    parameter int         ROM_LATENCY = 2,
    parameter int         MAX_RETRY   = 3,
    parameter int         GAP_CYCLES  = 500,
    parameter logic [7:0] END_MARKER  = 8'hFF
) (
    input  logic       clk_ref,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_q,
    output logic       wr_req,
    output logic [7:0] wr_dev,
    output logic [7:0] wr_reg,
    output logic [7:0] wr_data,
    input  logic       wr_ack,
    input  logic       wr_done,
    input  logic       wr_nack,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [4:0] entry_idx
);

    localparam int LAT_W = (ROM_LATENCY > 0) ? $clog2(ROM_LATENCY + 1) : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int RTY_W = $clog2(MAX_RETRY + 2);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH_DEV, S_FETCH_REG, S_FETCH_DATA,
        S_ISSUE, S_WAIT, S_GAP, S_DONE, S_ERROR
    } state_t;

    state_t            state_q;
    logic [7:0]        rom_addr_q, base_q, base_d;
    logic [7:0]        wr_dev_q, wr_reg_q, wr_data_q;
    logic              wr_req_q, busy_q, done_q, error_q, nack_q;
    logic [4:0]        entry_idx_q;
    logic [LAT_W-1:0]  lat_q;
    logic [GAP_W-1:0]  gap_q;
    logic [RTY_W-1:0]  retry_q, retry_d;

    // Next entry base (stride 3 by addition) and retry count after a completion.
    always_comb begin
        base_d  = base_q + 8'd3;
        retry_d = wr_nack ? retry_q + RTY_W'(1) : '0;
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk_ref or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= '0;
            base_q      <= '0;
            wr_dev_q    <= '0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
            wr_req_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            nack_q      <= 1'b0;
            entry_idx_q <= '0;
            lat_q       <= '0;
            gap_q       <= '0;
            retry_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q     <= S_FETCH_DEV;
                        rom_addr_q  <= '0;
                        base_q      <= '0;
                        entry_idx_q <= '0;
                        retry_q     <= '0;
                        lat_q       <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                    end
                end
                S_FETCH_DEV: begin
                    if (lat_q == LAT_W'(ROM_LATENCY)) begin
                        wr_dev_q <= rom_q;
                        if (rom_q == END_MARKER) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q    <= S_FETCH_REG;
                            rom_addr_q <= base_q + 8'd1;
                            lat_q      <= '0;
                        end
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                S_FETCH_REG: begin
                    if (lat_q == LAT_W'(ROM_LATENCY)) begin
                        wr_reg_q   <= rom_q;
                        state_q    <= S_FETCH_DATA;
                        rom_addr_q <= base_q + 8'd2;
                        lat_q      <= '0;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                S_FETCH_DATA: begin
                    if (lat_q == LAT_W'(ROM_LATENCY)) begin
                        wr_data_q <= rom_q;
                        state_q   <= S_ISSUE;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                S_ISSUE: begin
                    // First ISSUE cycle raises wr_req; ack only counts while it is high.
                    if (!wr_req_q) begin
                        wr_req_q <= 1'b1;
                    end else if (wr_ack) begin
                        wr_req_q <= 1'b0;
                        if (wr_done) begin
                            // Combined ack+done master: skip WAIT entirely.
                            state_q <= S_GAP;
                            gap_q   <= GAP_W'(GAP_CYCLES);
                            retry_q <= retry_d;
                            nack_q  <= wr_nack;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wr_done) begin
                        state_q <= S_GAP;
                        gap_q   <= GAP_W'(GAP_CYCLES);
                        retry_q <= retry_d;
                        nack_q  <= wr_nack;
                    end
                end
                S_GAP: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - GAP_W'(1);
                    end else if (!nack_q) begin
                        if (entry_idx_q == 5'(NUM_ENTRIES - 1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q     <= S_FETCH_DEV;
                            entry_idx_q <= entry_idx_q + 5'd1;
                            base_q      <= base_d;
                            rom_addr_q  <= base_d;
                            lat_q       <= '0;
                        end
                    end else if (retry_q <= RTY_W'(MAX_RETRY)) begin
                        state_q <= S_ISSUE;
                    end else begin
                        state_q <= S_ERROR;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rom_addr  = rom_addr_q;
    assign wr_req    = wr_req_q;
    assign wr_dev    = wr_dev_q;
    assign wr_reg    = wr_reg_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign entry_idx = entry_idx_q;

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// Scoreboard bench for hdmi_cfg_sequencer: 3-entry ROM, stub I2C master.
module tb_hdmi_cfg_sequencer;

    localparam int N   = 3;
    localparam int L   = 2;
    localparam int GAP = 500;
    localparam int GAP_NEXT  = GAP + 1 + 3 * (L + 1) + 1;  // 511
    localparam int GAP_RETRY = GAP + 2;                    // 502

    logic       clk_ref = 1'b0;
    logic       reset, start;
    logic [7:0] rom_addr, rom_q, rom_p1;
    logic       wr_req, wr_ack, wr_done, wr_nack;
    logic [7:0] wr_dev, wr_reg, wr_data;
    logic       busy, done, error;
    logic [4:0] entry_idx;

    always #5 clk_ref = ~clk_ref;

    hdmi_cfg_sequencer #(
        .NUM_ENTRIES(N), .ROM_LATENCY(L), .MAX_RETRY(3),
        .GAP_CYCLES(GAP), .END_MARKER(8'hFF)
    ) dut (
        .clk_ref(clk_ref), .reset(reset), .start(start),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .wr_req(wr_req), .wr_dev(wr_dev), .wr_reg(wr_reg), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_done(wr_done), .wr_nack(wr_nack),
        .busy(busy), .done(done), .error(error), .entry_idx(entry_idx)
    );

    // Two-stage ROM: data valid two edges after the address changes.
    logic [7:0] rom_mem [0:15];
    always_ff @(posedge clk_ref) begin
        rom_p1 <= rom_mem[rom_addr[3:0]];
        rom_q  <= rom_p1;
    end

    int cyc = 0;
    always @(posedge clk_ref) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct { logic [7:0] dev; logic [7:0] rg; logic [7:0] dat; int gap; } wr_t;
    typedef struct { logic dn; logic er; logic [4:0] idx; } fin_t;
    wr_t        exp_wr[$];
    fin_t       exp_fin[$];
    bit         resp_q[$];
    logic [7:0] trace_q[$];
    int         done_cyc = 0;

    task automatic push_w(input logic [7:0] d, input logic [7:0] r, input logic [7:0] v, input int g);
        wr_t w;
        w.dev = d; w.rg = r; w.dat = v; w.gap = g;
        exp_wr.push_back(w);
    endtask

    task automatic push_f(input logic d, input logic e, input logic [4:0] i);
        fin_t f;
        f.dn = d; f.er = e; f.idx = i;
        exp_fin.push_back(f);
    endtask

    task automatic push_table(input int first_gap);
        push_w(8'h72, 8'h41, 8'h10, first_gap);
        push_w(8'h72, 8'h98, 8'h03, GAP_NEXT);
        push_w(8'h7A, 8'h00, 8'h00, GAP_NEXT);
    endtask

    // Stub I2C master: ack on first sight of wr_req, done 20 cycles later.
    int m_cnt = 0;
    bit m_nack = 1'b0;
    initial begin
        wr_ack = 1'b0; wr_done = 1'b0; wr_nack = 1'b0;
        forever begin
            @(negedge clk_ref);
            wr_ack = 1'b0; wr_done = 1'b0; wr_nack = 1'b0;
            if (reset) begin
                m_cnt = 0;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    wr_done  = 1'b1;
                    wr_nack  = m_nack;
                    done_cyc = cyc + 1;
                end
            end else if (wr_req) begin
                wr_ack = 1'b1;
                m_cnt  = 20;
                m_nack = (resp_q.size() > 0) ? resp_q.pop_front() : 1'b0;
            end
        end
    end

    // Monitor: pops expectations on wr_req rise and on done/error rise.
    initial begin
        wr_t  w;
        fin_t f;
        logic req_p = 1'b0;
        logic fin_p = 1'b0;
        logic [7:0] addr_p = 8'h00;
        forever begin
            @(negedge clk_ref);
            if (rom_addr !== addr_p) begin
                trace_q.push_back(rom_addr);
                addr_p = rom_addr;
            end
            if (wr_req && !req_p) begin
                if (exp_wr.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected wr_req: dev 0x%0h reg 0x%0h data 0x%0h, none expected",
                             wr_dev, wr_reg, wr_data);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_dev", wr_dev, w.dev);
                    chk("wr_reg", wr_reg, w.rg);
                    chk("wr_data", wr_data, w.dat);
                    if (w.gap > 0) chk("gap cycles done->req", cyc - done_cyc, w.gap);
                end
            end
            if ((done || error) && !fin_p) begin
                if (exp_fin.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected finish: done %0b error %0b, none expected", done, error);
                end else begin
                    f = exp_fin.pop_front();
                    chk("done", done, f.dn);
                    chk("error", error, f.er);
                    chk("entry_idx", entry_idx, f.idx);
                    chk("busy at finish", busy, 0);
                end
            end
            req_p = wr_req;
            fin_p = done || error;
        end
    end

    task automatic pulse_start();
        @(negedge clk_ref); start = 1'b1;
        @(negedge clk_ref); start = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        int k = 0;
        while (!(done || error) && k < 20000) begin
            @(negedge clk_ref);
            k++;
        end
        if (k >= 20000) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout: no done/error within %0d cycles", nm, k);
        end
        repeat (2) @(negedge clk_ref);
        chk({nm, " writes left"}, exp_wr.size(), 0);
        chk({nm, " finishes left"}, exp_fin.size(), 0);
    endtask

    task automatic wait_req(input string nm, output int k);
        k = 0;
        while (!wr_req && k < 100) begin
            @(negedge clk_ref);
            k++;
        end
        if (k >= 100) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: wr_req not seen within %0d cycles", nm, k);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < 16; i++) rom_mem[i] = 8'h00;
        rom_mem[0] = 8'h72; rom_mem[1] = 8'h41; rom_mem[2] = 8'h10;
        rom_mem[3] = 8'h72; rom_mem[4] = 8'h98; rom_mem[5] = 8'h03;
        rom_mem[6] = 8'h7A; rom_mem[7] = 8'h00; rom_mem[8] = 8'h00;
        reset = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk_ref);
        chk("reset wr_req", wr_req, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset error", error, 0);
        chk("reset rom_addr", rom_addr, 0);
        chk("reset entry_idx", entry_idx, 0);
        reset = 1'b0;
        @(negedge clk_ref);

        // Plain 3-entry run.
        push_table(0);
        push_f(1'b1, 1'b0, 5'd2);
        pulse_start();
        chk("busy after start", busy, 1);
        wait_req("t1", k);
        chk("wr_req latency", k, 10);
        wait_end("t1");

        // Entry 1 NACKed twice then ACKed.
        resp_q.push_back(0); resp_q.push_back(1); resp_q.push_back(1);
        resp_q.push_back(0); resp_q.push_back(0);
        push_w(8'h72, 8'h41, 8'h10, 0);
        push_w(8'h72, 8'h98, 8'h03, GAP_NEXT);
        push_w(8'h72, 8'h98, 8'h03, GAP_RETRY);
        push_w(8'h72, 8'h98, 8'h03, GAP_RETRY);
        push_w(8'h7A, 8'h00, 8'h00, GAP_NEXT);
        push_f(1'b1, 1'b0, 5'd2);
        pulse_start();
        wait_end("t2");

        // Entry 0 NACKed four times -> error, then a clean restart.
        for (int i = 0; i < 4; i++) resp_q.push_back(1);
        push_w(8'h72, 8'h41, 8'h10, 0);
        for (int i = 0; i < 3; i++) push_w(8'h72, 8'h41, 8'h10, GAP_RETRY);
        push_f(1'b0, 1'b1, 5'd0);
        pulse_start();
        wait_end("t3 error");
        resp_q.delete();
        push_table(0);
        push_f(1'b1, 1'b0, 5'd2);
        pulse_start();
        chk("restart rom_addr", rom_addr, 0);
        chk("restart error cleared", error, 0);
        wait_end("t3 restart");

        // End marker on entry 1.
        rom_mem[3] = 8'hFF;
        push_w(8'h72, 8'h41, 8'h10, 0);
        push_f(1'b1, 1'b0, 5'd1);
        pulse_start();
        wait_end("t4");
        rom_mem[3] = 8'h72;

        // Reset while wr_req is high, then a full run.
        push_w(8'h72, 8'h41, 8'h10, 0);
        pulse_start();
        wait_req("t5", k);
        #2 reset = 1'b1;
        #1;
        chk("async reset wr_req", wr_req, 0);
        chk("async reset busy", busy, 0);
        chk("async reset rom_addr", rom_addr, 0);
        chk("async reset entry_idx", entry_idx, 0);
        chk("async reset wr_dev", wr_dev, 0);
        repeat (2) @(negedge clk_ref);
        reset = 1'b0;
        resp_q.delete();
        @(negedge clk_ref);
        push_table(0);
        push_f(1'b1, 1'b0, 5'd2);
        pulse_start();
        wait_end("t5");

        // Extra start pulses during FETCH_REG and WAIT are ignored.
        trace_q.delete();
        push_table(0);
        push_f(1'b1, 1'b0, 5'd2);
        pulse_start();
        repeat (3) @(negedge clk_ref);
        start = 1'b1;
        @(negedge clk_ref);
        start = 1'b0;
        wait_req("t6", k);
        repeat (5) @(negedge clk_ref);
        start = 1'b1;
        @(negedge clk_ref);
        start = 1'b0;
        wait_end("t6");
        chk("t6 rom_addr trace length", trace_q.size(), 9);
        for (int i = 0; i < 9 && i < trace_q.size(); i++)
            chk("t6 rom_addr trace", trace_q[i], i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
